// File: rtl/cache_pkg.sv
// Shared cache / memory-controller definitions: default geometry, derived sizes
// and the line responder state encoding.
package cache_pkg;

    localparam int DEFAULT_ADDRW     = 26;
    localparam int DEFAULT_LOG2DATAW = 5;
    localparam int DEFAULT_LOG2LINEW = 7;

    localparam int DATAW         = 1 << DEFAULT_LOG2DATAW;
    localparam int LINEW         = 1 << DEFAULT_LOG2LINEW;
    localparam int DATABYTES     = DATAW / 8;
    localparam int LINEBYTES     = LINEW / 8;
    localparam int LINEWORDS     = LINEW / DATAW;
    localparam int LOG2DATABYTES = DEFAULT_LOG2DATAW - 3;
    localparam int LOG2LINEBYTES = DEFAULT_LOG2LINEW - 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/line_word_sel.sv
// Finds the lowest line word at or after (inclusive) / after (exclusive) the given
// index whose byte-mask slice is non-zero; done=1 when no such word exists.
module line_word_sel #(
    parameter int LINE_WORDS = 4,
    parameter int DATA_BYTES = 4,
    parameter int IDX_W      = 2
) (
    input  logic [LINE_WORDS*DATA_BYTES-1:0] mask,
    input  logic [IDX_W-1:0]                 idx,
    input  logic                             inclusive,
    output logic [IDX_W-1:0]                 next_idx,
    output logic                             done
);

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        next_idx = '0;
        done     = 1'b1;
        // Scan downwards so the lowest qualifying word is the last one written.
        for (int w = LINE_WORDS - 1; w >= 0; w--) begin
            if ((|mask[w*DATA_BYTES +: DATA_BYTES]) &&
                ((w > int'(idx)) || (inclusive && (w == int'(idx))))) begin
                next_idx = IDX_W'(w);
                done     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_mem_responder.sv
// Memory-controller side of the cache line interface: turns one line fill or
// masked writeback into a burst of word beats on a narrow backing-memory port.
module line_mem_responder
    import cache_pkg::*;
#(
    parameter int ADDRW     = DEFAULT_ADDRW,
    parameter int LOG2DATAW = DEFAULT_LOG2DATAW,
    parameter int LOG2LINEW = DEFAULT_LOG2LINEW,
    localparam int DATA_W      = 1 << LOG2DATAW,
    localparam int LINE_W      = 1 << LOG2LINEW,
    localparam int DATA_BYTES  = DATA_W / 8,
    localparam int LINE_BYTES  = LINE_W / 8,
    localparam int LINE_WORDS  = LINE_W / DATA_W,
    localparam int LOG2_DBYTES = LOG2DATAW - 3,
    localparam int LOG2_LBYTES = LOG2LINEW - 3,
    localparam int IDX_W       = LOG2LINEW - LOG2DATAW,
    localparam int LADDR_W     = ADDRW - LOG2_LBYTES,
    localparam int WADDR_W     = ADDRW - LOG2_DBYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mc_req,
    input  logic                  mc_read,
    input  logic [ADDRW-1:0]      mc_paddr,
    input  logic [LINE_W-1:0]     mc_writeback_line,
    input  logic [LINE_BYTES-1:0] mc_writeback_mask,
    output logic                  mc_ack,
    output logic [LINE_W-1:0]     mc_fill_line,
    output logic                  mem_en,
    output logic [DATA_BYTES-1:0] mem_we,
    output logic [WADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready
);

    state_t                state, state_next;
    logic [LADDR_W-1:0]    line_addr, line_addr_next;
    logic                  is_read, is_read_next;
    logic [LINE_W-1:0]     wb_line, wb_line_next;
    logic [LINE_BYTES-1:0] wb_mask, wb_mask_next;
    logic [IDX_W-1:0]      word_idx, word_idx_next;

    logic                  mc_ack_next;
    logic [LINE_W-1:0]     fill_line_next;
    logic                  mem_en_next;
    logic [DATA_BYTES-1:0] mem_we_next;
    logic [WADDR_W-1:0]    mem_addr_next;
    logic [DATA_W-1:0]     mem_wdata_next;

    // Source of the beat being scheduled: live request in IDLE, latched copy in BEAT.
    logic                  idle;
    logic                  src_read;
    logic [LADDR_W-1:0]    src_laddr;
    logic [LINE_W-1:0]     src_line;
    logic [LINE_BYTES-1:0] src_mask;
    logic [IDX_W-1:0]      sel_idx_in;
    logic [IDX_W-1:0]      sel_next;
    logic                  sel_done;
    logic                  advance;

    logic unused_paddr_bits;
    assign unused_paddr_bits = ^mc_paddr[LOG2_LBYTES-1:0];

    assign idle       = (state == ST_IDLE);
    assign src_read   = idle ? mc_read : is_read;
    assign src_laddr  = idle ? mc_paddr[ADDRW-1:LOG2_LBYTES] : line_addr;
    assign src_line   = idle ? mc_writeback_line : wb_line;
    // A fill behaves like a writeback with every byte selected.
    assign src_mask   = idle ? (mc_read ? {LINE_BYTES{1'b1}} : mc_writeback_mask) : wb_mask;
    assign sel_idx_in = idle ? '0 : word_idx;
    assign advance    = (idle && mc_req) || ((state == ST_BEAT) && mem_ready);

    line_word_sel #(
        .LINE_WORDS (LINE_WORDS),
        .DATA_BYTES (DATA_BYTES),
        .IDX_W      (IDX_W)
    ) u_word_sel (
        .mask      (src_mask),
        .idx       (sel_idx_in),
        .inclusive (idle),
        .next_idx  (sel_next),
        .done      (sel_done)
    );

    always_comb begin
        state_next     = state;
        line_addr_next = line_addr;
        is_read_next   = is_read;
        wb_line_next   = wb_line;
        wb_mask_next   = wb_mask;
        word_idx_next  = word_idx;
        mc_ack_next    = 1'b0;
        fill_line_next = mc_fill_line;
        mem_en_next    = mem_en;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;

        if (idle && mc_req) begin
            line_addr_next = src_laddr;
            is_read_next   = mc_read;
            wb_line_next   = mc_writeback_line;
            wb_mask_next   = src_mask;
        end

        if ((state == ST_BEAT) && mem_ready && is_read) begin
            fill_line_next[word_idx*DATA_W +: DATA_W] = mem_rdata;
        end

        if (advance) begin
            if (sel_done) begin
                state_next  = ST_ACK;
                mc_ack_next = 1'b1;
                mem_en_next = 1'b0;
                mem_we_next = '0;
            end else begin
                state_next     = ST_BEAT;
                word_idx_next  = sel_next;
                mem_en_next    = 1'b1;
                mem_addr_next  = {src_laddr, sel_next};
                mem_we_next    = src_read ? '0 : src_mask[sel_next*DATA_BYTES +: DATA_BYTES];
                mem_wdata_next = src_read ? '0 : src_line[sel_next*DATA_W +: DATA_W];
            end
        end else if (state == ST_ACK) begin
            state_next = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            line_addr    <= '0;
            is_read      <= 1'b0;
            wb_line      <= '0;
            wb_mask      <= '0;
            word_idx     <= '0;
            mc_ack       <= 1'b0;
            mc_fill_line <= '0;
            mem_en       <= 1'b0;
            mem_we       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state        <= state_next;
            line_addr    <= line_addr_next;
            is_read      <= is_read_next;
            wb_line      <= wb_line_next;
            wb_mask      <= wb_mask_next;
            word_idx     <= word_idx_next;
            mc_ack       <= mc_ack_next;
            mc_fill_line <= fill_line_next;
            mem_en       <= mem_en_next;
            mem_we       <= mem_we_next;
            mem_addr     <= mem_addr_next;
            mem_wdata    <= mem_wdata_next;
        end
    end

endmodule
